// File: rtl/hash_target_filter.sv
// Compares the leading 64-bit hash word against a target and queues winning nonces in a FIFO.
// Define HASH_FILTER_BYTESWAP_EN to byte-reverse the word before it is compared and stored.
module hash_target_filter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1023:0]     in_hash,
  input  logic [63:0]       in_nonce,
  input  logic [63:0]       target,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_nonce,
  output logic [63:0]       out_word,
  output logic [CNT_W-1:0]  checked_cnt,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  function automatic logic [63:0] bswap(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = v[56-8*i +: 8];
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [63:0] w_in;
`ifdef HASH_FILTER_BYTESWAP_EN
  assign w_in = bswap(in_hash[1023:960]);
`else
  assign w_in = in_hash[1023:960];
`endif

  logic        s1_valid_q;
  logic [63:0] s1_word_q, s1_nonce_q, s1_target_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_word_q   <= '0;
      s1_nonce_q  <= '0;
      s1_target_q <= '0;
    end else if (clear) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_word_q   <= w_in;
        s1_nonce_q  <= in_nonce;
        s1_target_q <= target;
      end
    end
  end

  logic [63:0]      mem_nonce_q [DEPTH];
  logic [63:0]      mem_word_q  [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] checked_q, checked_d, hit_q, hit_d, drop_q, drop_d;
  logic             overflow_q, overflow_d;
  logic             hit, full, pop, push, drop;

  assign hit       = s1_valid_q && (s1_word_q < s1_target_q);
  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready && !clear;
  // A full FIFO still accepts a hit when the head leaves in the same cycle.
  assign push      = hit && (!full || pop) && !clear;
  assign drop      = hit && full && !pop && !clear;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    checked_d  = checked_q;
    hit_d      = hit_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      checked_d  = '0;
      hit_d      = '0;
      drop_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (s1_valid_q) checked_d = sat_inc(checked_q);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        hit_d    = sat_inc(hit_q);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (drop) begin
        drop_d     = sat_inc(drop_q);
        overflow_d = 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      checked_q  <= '0;
      hit_q      <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      checked_q  <= checked_d;
      hit_q      <= hit_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_nonce_q[wr_ptr_q] <= s1_nonce_q;
      mem_word_q[wr_ptr_q]  <= s1_word_q;
    end
  end

  assign out_nonce   = out_valid ? mem_nonce_q[rd_ptr_q] : '0;
  assign out_word    = out_valid ? mem_word_q[rd_ptr_q]  : '0;
  assign checked_cnt = checked_q;
  assign hit_cnt     = hit_q;
  assign drop_cnt    = drop_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_hash_target_filter.sv
// Directed bench for hash_target_filter: vector table plus multi-cycle FIFO/clear/reset sequences.
module tb_hash_target_filter;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [1023:0] in_hash = '0;
  logic [63:0]   in_nonce = '0;
  logic [63:0]   target = '0;
  logic          clear = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   out_nonce, out_word;
  logic [31:0]   checked_cnt, hit_cnt, drop_cnt;
  logic          overflow;

  int checks = 0;
  int failures = 0;

  hash_target_filter #(.DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_hash(in_hash),
    .in_nonce(in_nonce), .target(target), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_nonce(out_nonce),
    .out_word(out_word), .checked_cnt(checked_cnt), .hit_cnt(hit_cnt),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] word;
    logic [63:0] nonce;
    logic [63:0] tgt;
    bit          exp_hit;
    bit          exp_hit_sw;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [63:0] exp_word(input logic [63:0] w);
    logic [63:0] r;
`ifdef HASH_FILTER_BYTESWAP_EN
    for (int i = 0; i < 8; i++) r[8*i +: 8] = w[56-8*i +: 8];
`else
    r = w;
`endif
    return r;
  endfunction

  function automatic bit pick_hit(input vec_t v);
`ifdef HASH_FILTER_BYTESWAP_EN
    return v.exp_hit_sw;
`else
    return v.exp_hit;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic set_in(input logic v, input logic [63:0] word, input logic [63:0] nonce);
    in_valid = v;
    in_hash  = {word, {15{64'hA5A5_5A5A_C3C3_3C3C}}};
    in_nonce = nonce;
  endtask

  logic [63:0] exp_q[$];
  logic [63:0] head;

  initial begin
    vecs[0] = '{64'h0000_00FF_FFFF_FFFF, 64'h3dc787, 64'h0000_0100_0000_0000, 1'b1, 1'b0};
    vecs[1] = '{64'h1000,                64'h11,     64'h1000,                1'b0, 1'b0};
    vecs[2] = '{64'h0,                   64'h22,     64'h0,                   1'b0, 1'b0};
    vecs[3] = '{64'h0,                   64'h33,     64'h1,                   1'b1, 1'b1};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h44,     64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{64'h0FFF,                64'h55,     64'h1000,                1'b1, 1'b0};
    vecs[6] = '{64'h1001,                64'h66,     64'h1000,                1'b0, 1'b0};
    vecs[7] = '{64'hFF00_0000_0000_0000, 64'h77,     64'h0100,                1'b0, 1'b1};

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_nonce", out_nonce, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_counters", {checked_cnt, hit_cnt}, 0);
    chk("rst_drop_ovf", {drop_cnt, overflow}, 0);
    step();
    rst_n = 1'b1;
    step();

    // Single-result vectors: latency, strict compare, stored word
    for (int i = 0; i < 8; i++) begin
      do_clear();
      target = vecs[i].tgt;
      out_ready = 1'b0;
      set_in(1'b1, vecs[i].word, vecs[i].nonce);
      step();
      set_in(1'b0, 64'h0, 64'h0);
      chk($sformatf("v%0d_early_valid", i), out_valid, 0);
      step();
      chk($sformatf("v%0d_out_valid", i), out_valid, pick_hit(vecs[i]));
      chk($sformatf("v%0d_checked", i), checked_cnt, 1);
      chk($sformatf("v%0d_hit_cnt", i), hit_cnt, pick_hit(vecs[i]));
      if (pick_hit(vecs[i])) begin
        chk($sformatf("v%0d_nonce", i), out_nonce, vecs[i].nonce);
        chk($sformatf("v%0d_word", i), out_word, exp_word(vecs[i].word));
        step();
        chk($sformatf("v%0d_hold", i), out_nonce, vecs[i].nonce);
      end
      out_ready = 1'b1;
      step();
      chk($sformatf("v%0d_drained", i), out_valid, 0);
      out_ready = 1'b0;
    end

    // Overflow: 6 hits into a depth-4 FIFO with no reader
    do_clear();
    target = 64'h100;
    for (int n = 1; n <= 6; n++) begin
      set_in(1'b1, 64'h0, 64'(n));
      step();
    end
    set_in(1'b0, 64'h0, 64'h0);
    step();
    chk("ovf_checked", checked_cnt, 6);
    chk("ovf_hit_cnt", hit_cnt, 4);
    chk("ovf_drop_cnt", drop_cnt, 2);
    chk("ovf_flag", overflow, 1);
    out_ready = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      chk($sformatf("ovf_pop%0d_valid", n), out_valid, 1);
      chk($sformatf("ovf_pop%0d_nonce", n), out_nonce, 64'(n));
      step();
    end
    chk("ovf_empty", out_valid, 0);
    chk("ovf_sticky", overflow, 1);
    out_ready = 1'b0;

    // Full FIFO with simultaneous push and pop, then 10 hits wrapping the pointers
    do_clear();
    exp_q.delete();
    for (int n = 0; n < 4; n++) begin
      set_in(1'b1, 64'h0, 64'(10 + n));
      exp_q.push_back(64'(10 + n));
      step();
    end
    set_in(1'b0, 64'h0, 64'h0);
    step();
    for (int n = 0; n < 10; n++) begin
      set_in(1'b1, 64'h0, 64'(20 + n));
      exp_q.push_back(64'(20 + n));
      out_ready = (n > 0);
      if (out_valid && out_ready) begin
        head = exp_q.pop_front();
        chk($sformatf("wrap_nonce%0d", n), out_nonce, head);
      end
      step();
      chk($sformatf("wrap_valid%0d", n), out_valid, 1);
    end
    set_in(1'b0, 64'h0, 64'h0);
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (out_valid && exp_q.size() > 0) begin
        head = exp_q.pop_front();
        chk($sformatf("wrap_drain%0d", n), out_nonce, head);
      end
      step();
    end
    chk("wrap_all_popped", 64'(exp_q.size()), 0);
    chk("wrap_empty", out_valid, 0);
    chk("wrap_hit_cnt", hit_cnt, 14);
    chk("wrap_drop_cnt", drop_cnt, 0);
    chk("wrap_ovf", overflow, 0);
    out_ready = 1'b0;

    // Clear in the same cycle as a hit, with 2 entries queued
    do_clear();
    set_in(1'b1, 64'h0, 64'd40);
    step();
    set_in(1'b1, 64'h0, 64'd41);
    step();
    set_in(1'b0, 64'h0, 64'h0);
    step();
    chk("clr_pre_valid", out_valid, 1);
    set_in(1'b1, 64'h0, 64'd42);
    clear = 1'b1;
    step();
    clear = 1'b0;
    set_in(1'b0, 64'h0, 64'h0);
    chk("clr_valid", out_valid, 0);
    chk("clr_counters", {checked_cnt, hit_cnt, drop_cnt}, 0);
    chk("clr_ovf", overflow, 0);
    step();
    step();
    chk("clr_no_late_push", out_valid, 0);
    chk("clr_no_late_count", {checked_cnt, hit_cnt}, 0);

    // Asynchronous reset mid-cycle with 3 entries queued
    for (int n = 0; n < 3; n++) begin
      set_in(1'b1, 64'h0, 64'(50 + n));
      step();
    end
    set_in(1'b0, 64'h0, 64'h0);
    step();
    chk("arst_pre_hits", hit_cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_nonce", out_nonce, 0);
    chk("arst_counters", {checked_cnt, hit_cnt}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_after", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
